// File: rtl/taliesin_cond_pkg.sv
// Shared ISA constants for the Taliesin condition unit: CR bit layout,
// condition codes, ALU op codes and the flag/condition helper functions.
package taliesin_cond_pkg;

    // CR / ALU flag bit positions, flags vector is {V,C,Z,N}
    localparam int unsigned CR_N = 0;
    localparam int unsigned CR_Z = 1;
    localparam int unsigned CR_C = 2;
    localparam int unsigned CR_V = 3;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned COND_W = 4;
    localparam int unsigned FLAG_W = 4;

    // ALU operation codes
    localparam logic [OP_W-1:0] OP_NOP  = 8'h00;
    localparam logic [OP_W-1:0] OP_ADD  = 8'h01;
    localparam logic [OP_W-1:0] OP_ADDU = 8'h02;
    localparam logic [OP_W-1:0] OP_SUB  = 8'h03;
    localparam logic [OP_W-1:0] OP_CMP  = 8'h04;
    localparam logic [OP_W-1:0] OP_AND  = 8'h05;
    localparam logic [OP_W-1:0] OP_OR   = 8'h06;
    localparam logic [OP_W-1:0] OP_NOT  = 8'h07;
    localparam logic [OP_W-1:0] OP_LSL  = 8'h08;
    localparam logic [OP_W-1:0] OP_LSR  = 8'h09;
    localparam logic [OP_W-1:0] OP_ASR  = 8'h0A;
    localparam logic [OP_W-1:0] OP_LW   = 8'h10;
    localparam logic [OP_W-1:0] OP_SW   = 8'h11;
    localparam logic [OP_W-1:0] OP_B    = 8'h20;

    // Branch condition codes
    localparam logic [COND_W-1:0] COND_EQ = 4'h0;
    localparam logic [COND_W-1:0] COND_NE = 4'h1;
    localparam logic [COND_W-1:0] COND_CS = 4'h2;
    localparam logic [COND_W-1:0] COND_CC = 4'h3;
    localparam logic [COND_W-1:0] COND_MI = 4'h4;
    localparam logic [COND_W-1:0] COND_PL = 4'h5;
    localparam logic [COND_W-1:0] COND_VS = 4'h6;
    localparam logic [COND_W-1:0] COND_VC = 4'h7;
    localparam logic [COND_W-1:0] COND_HI = 4'h8;
    localparam logic [COND_W-1:0] COND_LS = 4'h9;
    localparam logic [COND_W-1:0] COND_GE = 4'hA;
    localparam logic [COND_W-1:0] COND_LT = 4'hB;
    localparam logic [COND_W-1:0] COND_GT = 4'hC;
    localparam logic [COND_W-1:0] COND_LE = 4'hD;
    localparam logic [COND_W-1:0] COND_AL = 4'hE;
    localparam logic [COND_W-1:0] COND_NV = 4'hF;

    // True for ALU ops that write the condition register
    function automatic logic is_flag_op(input logic [OP_W-1:0] op);
        logic r;
        case (op)
            OP_ADD, OP_ADDU, OP_SUB, OP_CMP, OP_AND,
            OP_OR, OP_NOT, OP_LSL, OP_LSR, OP_ASR: r = 1'b1;
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

    // Evaluate a condition code against a {V,C,Z,N} flag vector
    function automatic logic cond_eval(input logic [COND_W-1:0] cond,
                                       input logic [FLAG_W-1:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic r;
        n = flags[CR_N];
        z = flags[CR_Z];
        c = flags[CR_C];
        v = flags[CR_V];
        case (cond)
            COND_EQ: r = z;
            COND_NE: r = !z;
            COND_CS: r = c;
            COND_CC: r = !c;
            COND_MI: r = n;
            COND_PL: r = !n;
            COND_VS: r = v;
            COND_VC: r = !v;
            COND_HI: r = c && !z;
            COND_LS: r = !c || z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = !z && (n == v);
            COND_LE: r = z || (n != v);
            COND_AL: r = 1'b1;
            COND_NV: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/taliesin_cond_eval.sv
// Combinational condition decode; also intended for future predication logic.
module taliesin_cond_eval
    import taliesin_cond_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              taken_c
);

    // Pure decode of the condition code against the supplied flags
    always_comb begin
        taken_c = cond_eval(cond, flags);
    end

endmodule

// File: rtl/taliesin_cond_unit.sv
// Taliesin condition unit: owns CR, tracks flag-writing ops in flight and
// resolves conditional branches over a valid/ready request/response pair.
// Optional macro TALIESIN_COND_FWD_EN enables same-cycle flag forwarding
// from the ALU result into branch resolution.
module taliesin_cond_unit
    import taliesin_cond_pkg::*;
#(
    parameter int unsigned PEND_MAX   = 3,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned INSN_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_flag_op,
    output logic              iss_ready,
    input  logic              res_valid,
    input  logic [OP_W-1:0]   res_op,
    input  logic [FLAG_W-1:0] res_flags,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [COND_W-1:0] br_cond,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_resp_valid,
    input  logic              br_resp_ready,
    output logic              br_taken,
    output logic [ADDR_W-1:0] br_next_pc,
    output logic [FLAG_W-1:0] cr,
    output logic              err_underflow
);

    localparam int unsigned PEND_W = $clog2(PEND_MAX + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [PEND_W-1:0]   pend_q;
    logic                flag_res;
    logic                inc;
    logic                dec;
    logic                flags_stable;
    logic                accept;
    logic                taken_c;
    logic [FLAG_W-1:0]   eff_flags;
    logic [ADDR_W-1:0]   next_pc_c;

    assign flag_res  = res_valid && is_flag_op(res_op);
    assign iss_ready = (pend_q < PEND_W'(PEND_MAX));
    assign inc       = iss_flag_op && iss_ready;
    assign dec       = flag_res;

`ifdef TALIESIN_COND_FWD_EN
    // Last outstanding writer retiring this cycle is forwarded straight in
    assign flags_stable = (pend_q == '0) ||
                          ((pend_q == PEND_W'(1)) && flag_res && !iss_flag_op);
    assign eff_flags    = flag_res ? res_flags : cr;
`else
    // Branch waits until CR itself holds the last written flags
    assign flags_stable = (pend_q == '0) && !flag_res;
    assign eff_flags    = cr;
`endif

    taliesin_cond_eval u_cond_eval (
        .cond    (br_cond),
        .flags   (eff_flags),
        .taken_c (taken_c)
    );

    assign next_pc_c     = taken_c ? br_target : br_pc + ADDR_W'(INSN_BYTES);
    assign br_resp_valid = (state_q == ST_RESP);

    // In-flight flag-writer counter with sticky underflow detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q        <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (inc && !dec) begin
                pend_q <= pend_q + PEND_W'(1);
            end else if (dec && !inc && (pend_q != '0)) begin
                pend_q <= pend_q - PEND_W'(1);
            end
            if (dec && (pend_q == '0)) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // Condition register update from flag-writing results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr <= '0;
        end else if (flag_res) begin
            cr <= res_flags;
        end
    end

    // Branch FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Branch FSM next state and request acceptance
    always_comb begin
        state_d  = state_q;
        br_ready = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                br_ready = flags_stable;
                if (br_valid && flags_stable) begin
                    accept  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (br_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response payload captured at acceptance and held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken   <= 1'b0;
            br_next_pc <= '0;
        end else if (accept) begin
            br_taken   <= taken_c;
            br_next_pc <= next_pc_c;
        end
    end

endmodule

// File: tb/tb_taliesin_cond_unit.sv
// Self-checking bench for taliesin_cond_unit: reset, directed corners,
// a condition/next-PC vector table and a randomized run against a model.
module tb_taliesin_cond_unit;
    import taliesin_cond_pkg::*;

    localparam int unsigned PEND = 3;

    logic        clk;
    logic        rst_n;
    logic        iss_flag_op;
    logic        iss_ready;
    logic        res_valid;
    logic [7:0]  res_op;
    logic [3:0]  res_flags;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_cond;
    logic [31:0] br_pc;
    logic [31:0] br_target;
    logic        br_resp_valid;
    logic        br_resp_ready;
    logic        br_taken;
    logic [31:0] br_next_pc;
    logic [3:0]  cr;
    logic        err_underflow;

    int n_tests;
    int n_fail;

    taliesin_cond_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iss_flag_op   (iss_flag_op),
        .iss_ready     (iss_ready),
        .res_valid     (res_valid),
        .res_op        (res_op),
        .res_flags     (res_flags),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_cond       (br_cond),
        .br_pc         (br_pc),
        .br_target     (br_target),
        .br_resp_valid (br_resp_valid),
        .br_resp_ready (br_resp_ready),
        .br_taken      (br_taken),
        .br_next_pc    (br_next_pc),
        .cr            (cr),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cond;
        logic [3:0]  flags;
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [31:0] next_pc;
    } vec_t;

    vec_t       vecs[16];
    logic [7:0] flag_ops[10];

    // Model state
    int          m_pend;
    logic [3:0]  m_cr;
    logic        m_err;
    logic        m_busy;
    logic        m_taken;
    logic [31:0] m_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        iss_flag_op   = 1'b0;
        res_valid     = 1'b0;
        res_op        = OP_NOP;
        res_flags     = 4'h0;
        br_valid      = 1'b0;
        br_cond       = 4'h0;
        br_pc         = 32'h0;
        br_target     = 32'h0;
        br_resp_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_flag_op(input logic [7:0] op);
        foreach (flag_ops[k]) begin
            if (flag_ops[k] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Condition codes come in pairs; the odd member is the negation of the even one.
    function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic p;
        n = f[0];
        z = f[1];
        c = f[2];
        v = f[3];
        case (cond[3:1])
            3'd0:    p = z;
            3'd1:    p = c;
            3'd2:    p = n;
            3'd3:    p = v;
            3'd4:    p = c && !z;
            3'd5:    p = (n == v);
            3'd6:    p = !z && (n == v);
            default: p = 1'b1;
        endcase
        return p ^ cond[0];
    endfunction

    initial begin
        logic        fr;
        logic        stable;
        logic        exp_br_ready;
        logic        inc;
        logic [3:0]  eff;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle_inputs();
        flag_ops = '{OP_ADD, OP_ADDU, OP_SUB, OP_CMP, OP_AND,
                     OP_OR, OP_NOT, OP_LSL, OP_LSR, OP_ASR};
        vecs[0]  = '{COND_EQ, 4'b0010, 32'h100,  32'h200,  1'b1, 32'h200};
        vecs[1]  = '{COND_NE, 4'b0010, 32'h100,  32'h200,  1'b0, 32'h104};
        vecs[2]  = '{COND_CS, 4'b0100, 32'h100,  32'h200,  1'b1, 32'h200};
        vecs[3]  = '{COND_CC, 4'b0100, 32'h100,  32'h200,  1'b0, 32'h104};
        vecs[4]  = '{COND_MI, 4'b0001, 32'h1000, 32'h800,  1'b1, 32'h800};
        vecs[5]  = '{COND_PL, 4'b0001, 32'h1000, 32'h800,  1'b0, 32'h1004};
        vecs[6]  = '{COND_VS, 4'b1000, 32'h2000, 32'h40,   1'b1, 32'h40};
        vecs[7]  = '{COND_VC, 4'b1000, 32'h2000, 32'h40,   1'b0, 32'h2004};
        vecs[8]  = '{COND_HI, 4'b0100, 32'h100,  32'h200,  1'b1, 32'h200};
        vecs[9]  = '{COND_LS, 4'b0100, 32'h100,  32'h200,  1'b0, 32'h104};
        vecs[10] = '{COND_GE, 4'b1001, 32'h100,  32'h200,  1'b1, 32'h200};
        vecs[11] = '{COND_GT, 4'b1011, 32'h100,  32'h200,  1'b0, 32'h104};
        vecs[12] = '{COND_LE, 4'b0001, 32'h100,  32'h200,  1'b1, 32'h200};
        vecs[13] = '{COND_LT, 4'b1000, 32'h100,  32'h200,  1'b1, 32'h200};
        vecs[14] = '{COND_AL, 4'b0000, 32'hABC0, 32'h10,   1'b1, 32'h10};
        vecs[15] = '{COND_NV, 4'b0000, 32'hFFFFFFFC, 32'h1234, 1'b0, 32'h0};

        // Reset values
        #2;
        chk("rst cr", 32'(cr), 32'h0);
        chk("rst resp_valid", 32'(br_resp_valid), 32'h0);
        chk("rst iss_ready", 32'(iss_ready), 32'h1);
        chk("rst err", 32'(err_underflow), 32'h0);
        chk("rst taken", 32'(br_taken), 32'h0);
        chk("rst next_pc", br_next_pc, 32'h0);
        chk("rst br_ready", 32'(br_ready), 32'h1);
        step();
        rst_n = 1'b1;

        // Async reset with pend=2, RESP active, err set and CR nonzero
        res_valid = 1'b1; res_op = OP_ADD; res_flags = 4'h5;
        step(); idle_inputs();
        chk("pre err", 32'(err_underflow), 32'h1);
        iss_flag_op = 1'b1;
        step(); idle_inputs();
        res_valid = 1'b1; res_op = OP_CMP; res_flags = 4'hF;
        step(); idle_inputs();
        br_valid = 1'b1; br_cond = COND_AL; br_pc = 32'h40; br_target = 32'h80;
        step(); idle_inputs();
        br_resp_ready = 1'b0; iss_flag_op = 1'b1;
        step(); step();
        iss_flag_op = 1'b0;
        chk("pre resp_valid", 32'(br_resp_valid), 32'h1);
        chk("pre cr", 32'(cr), 32'hF);
        chk("pre next_pc", br_next_pc, 32'h80);
        #2 rst_n = 1'b0;
        #1;
        chk("async cr", 32'(cr), 32'h0);
        chk("async resp_valid", 32'(br_resp_valid), 32'h0);
        chk("async iss_ready", 32'(iss_ready), 32'h1);
        chk("async err", 32'(err_underflow), 32'h0);
        chk("async taken", 32'(br_taken), 32'h0);
        chk("async next_pc", br_next_pc, 32'h0);
        step();
        rst_n = 1'b1;
        idle_inputs();

        // Pending counter saturation
        iss_flag_op = 1'b1;
        repeat (3) step();
        #1;
        chk("full iss_ready", 32'(iss_ready), 32'h0);
        chk("full br_ready", 32'(br_ready), 32'h0);
        step();
        iss_flag_op = 1'b0;
        #1;
        chk("4th ignored iss_ready", 32'(iss_ready), 32'h0);
        step();
        res_valid = 1'b1; res_op = OP_ADD; res_flags = 4'h0;
        step(); idle_inputs();
        #1;
        chk("pend2 iss_ready", 32'(iss_ready), 32'h1);
        res_valid = 1'b1; res_op = OP_ADD;
        step(); idle_inputs();
        #1;
        chk("pend1 br_ready", 32'(br_ready), 32'h0);
        res_valid = 1'b1; res_op = OP_ADD;
        step(); idle_inputs();
        #1;
        chk("pend0 br_ready", 32'(br_ready), 32'h1);
        chk("drain err", 32'(err_underflow), 32'h0);
        step();

        // Condition / next-PC table
        for (int i = 0; i < 16; i++) begin
            iss_flag_op = 1'b1;
            step(); idle_inputs();
            res_valid = 1'b1; res_op = OP_CMP; res_flags = vecs[i].flags;
            step(); idle_inputs();
            br_valid = 1'b1; br_cond = vecs[i].cond;
            br_pc = vecs[i].pc; br_target = vecs[i].target;
            #1;
            chk($sformatf("vec%0d br_ready", i), 32'(br_ready), 32'h1);
            step(); idle_inputs();
            chk($sformatf("vec%0d resp_valid", i), 32'(br_resp_valid), 32'h1);
            chk($sformatf("vec%0d cr", i), 32'(cr), 32'(vecs[i].flags));
            chk($sformatf("vec%0d taken", i), 32'(br_taken), 32'(vecs[i].taken));
            chk($sformatf("vec%0d next_pc", i), br_next_pc, vecs[i].next_pc);
            step();
        end

        // Branch racing the last flag write (pend=1, SUB N=1 V=0, LT)
        iss_flag_op = 1'b1;
        step(); idle_inputs();
        res_valid = 1'b1; res_op = OP_SUB; res_flags = 4'b0001;
        br_valid = 1'b1; br_cond = COND_LT; br_pc = 32'h300; br_target = 32'h400;
        #1;
`ifdef TALIESIN_COND_FWD_EN
        chk("fwd br_ready", 32'(br_ready), 32'h1);
        step();
        res_valid = 1'b0; br_valid = 1'b0;
`else
        chk("nofwd br_ready stall", 32'(br_ready), 32'h0);
        step();
        res_valid = 1'b0;
        #1;
        chk("nofwd br_ready next", 32'(br_ready), 32'h1);
        step();
        br_valid = 1'b0;
`endif
        chk("race resp_valid", 32'(br_resp_valid), 32'h1);
        chk("race taken", 32'(br_taken), 32'h1);
        chk("race next_pc", br_next_pc, 32'h400);
        step(); idle_inputs();

        // Response back-pressure: CR=0001 so GT is not taken
        br_valid = 1'b1; br_cond = COND_GT; br_pc = 32'h500; br_target = 32'h900;
        step();
        br_cond = COND_AL; br_target = 32'hABC; br_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d resp_valid", i), 32'(br_resp_valid), 32'h1);
            chk($sformatf("stall%0d br_ready", i), 32'(br_ready), 32'h0);
            chk($sformatf("stall%0d taken", i), 32'(br_taken), 32'h0);
            chk($sformatf("stall%0d next_pc", i), br_next_pc, 32'h504);
            step();
        end
        br_resp_ready = 1'b1;
        #1;
        chk("release resp_valid", 32'(br_resp_valid), 32'h1);
        step();
        br_valid = 1'b0;
        chk("idle resp_valid", 32'(br_resp_valid), 32'h0);
        chk("idle br_ready", 32'(br_ready), 32'h1);
        idle_inputs();

        // Underflow is sticky; SW leaves CR alone; NV at top of memory wraps
        res_valid = 1'b1; res_op = OP_ADD; res_flags = 4'hA;
        step(); idle_inputs();
        chk("uflow err", 32'(err_underflow), 32'h1);
        chk("uflow cr", 32'(cr), 32'hA);
        step(); step();
        chk("uflow sticky", 32'(err_underflow), 32'h1);
        res_valid = 1'b1; res_op = OP_SW; res_flags = 4'h5;
        step(); idle_inputs();
        chk("sw cr hold", 32'(cr), 32'hA);
        br_valid = 1'b1; br_cond = COND_NV; br_pc = 32'hFFFFFFFC; br_target = 32'h10;
        step(); idle_inputs();
        chk("wrap taken", 32'(br_taken), 32'h0);
        chk("wrap next_pc", br_next_pc, 32'h0);
        step();

        // Randomized run against the behavioural model
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        idle_inputs();
        m_pend = 0; m_cr = 4'h0; m_err = 1'b0; m_busy = 1'b0;
        m_taken = 1'b0; m_next = 32'h0;
        for (int i = 0; i < 400; i++) begin
            iss_flag_op = ($urandom_range(0, 2) == 0);
            res_valid   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 7) res_op = flag_ops[$urandom_range(0, 9)];
            else if ($urandom_range(0, 1) == 0) res_op = OP_SW;
            else res_op = 8'($urandom_range(0, 255));
            res_flags     = 4'($urandom);
            br_valid      = ($urandom_range(0, 1) == 0);
            br_cond       = 4'($urandom);
            br_pc         = $urandom;
            br_target     = $urandom;
            br_resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            fr = res_valid && ref_flag_op(res_op);
`ifdef TALIESIN_COND_FWD_EN
            stable = (m_pend == 0) || (m_pend == 1 && fr && !iss_flag_op);
            eff    = fr ? res_flags : m_cr;
`else
            stable = (m_pend == 0) && !fr;
            eff    = m_cr;
`endif
            exp_br_ready = !m_busy && stable;
            chk("rnd iss_ready", 32'(iss_ready), 32'(m_pend < PEND));
            chk("rnd br_ready", 32'(br_ready), 32'(exp_br_ready));
            if (m_busy) begin
                if (br_resp_ready) m_busy = 1'b0;
            end else if (br_valid && exp_br_ready) begin
                m_busy  = 1'b1;
                m_taken = ref_cond(br_cond, eff);
                m_next  = m_taken ? br_target : br_pc + 32'd4;
            end
            inc = iss_flag_op && (m_pend < PEND);
            if (fr && m_pend == 0) m_err = 1'b1;
            if (inc && !fr) m_pend++;
            else if (fr && !inc && m_pend > 0) m_pend--;
            if (fr) m_cr = res_flags;
            step();
            chk("rnd resp_valid", 32'(br_resp_valid), 32'(m_busy));
            chk("rnd cr", 32'(cr), 32'(m_cr));
            chk("rnd err", 32'(err_underflow), 32'(m_err));
            if (m_busy) begin
                chk("rnd taken", 32'(br_taken), 32'(m_taken));
                chk("rnd next_pc", br_next_pc, m_next);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
